ttt_turn_arbiter: RTL and testbench
===================================

Name: ttt_turn_arbiter

Overview:
- Sequences player moves into the tic-tac-toe board datapath (ttt_main-style board: nine 2-bit cells plus a `who` result).
- Enforces turn order and edge-detects the level-held player enables.
- Rejects illegal and occupied positions, applies a per-turn timeout, and issues exactly one write strobe per accepted move.
- Stops accepting moves once the board reports a win or a draw.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles a player may idle on their turn before forfeiting it; 0 disables the timeout.
- TMR_W, 16, timeout counter width; TIMEOUT_CYCLES must be < 2^TMR_W.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- player1_enable  in  1  P1 move request, level; a move is its 0->1 edge.
- player2_enable  in  1  P2 move request, level; a move is its 0->1 edge.
- player1_position  in  4  P1 cell index, 0..8.
- player2_position  in  4  P2 cell index, 0..8.
- board_cells  in  18  board state; cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2.
- who  in  2  board result: 00 none, 01 P1 wins, 10 P2 wins, 11 draw.
- wr_en  out  1  one-cycle write strobe to the board.
- wr_pos  out  4  cell index for the write.
- wr_player  out  2  mark to write: 01 or 10.
- turn  out  2  player to move: 01 P1, 10 P2, 00 game over.
- illegal_move  out  1  one-cycle pulse: bad or occupied position.
- out_of_turn  out  1  one-cycle pulse: non-turn player raised enable.
- timeout  out  1  one-cycle pulse: turn forfeited.
- move_count  out  4  accepted moves, 0..9.
- game_over  out  1  sticky until reset.

Behaviour:
- Reset (reset==0 at posedge):
  - state=WAIT_P1, turn=01; wr_en, pulses, move_count, game_over and the timer all 0; wr_pos=0, wr_player=00.
  - Enable history registers (en1_d, en2_d) load 1. An enable held high through reset therefore must drop before it counts.
- Edge detect: edgeN = playerN_enable & ~enN_d. enN_d <= playerN_enable on every non-reset cycle in all states. Edges arriving outside WAIT_Px are discarded, not queued.
- States: WAIT_P1, WAIT_P2, COMMIT, CHECK, DONE.
- WAIT_Px, turn-player edge at posedge k: position p is sampled at k.
  - p>8 or board_cells cell p != 00: illegal_move=1 in cycle k+1; stay in WAIT_Px; timer keeps running.
  - Otherwise latch wr_pos=p and wr_player=x, and go to COMMIT.
- COMMIT: wr_en=1 for exactly one cycle (cycle k+1); move_count increments in the same cycle. Next state CHECK.
- CHECK (cycle k+2, board has updated): evaluate `who`.
  - who!=00 or move_count==9: go to DONE, game_over=1, turn=00.
  - Otherwise go to the other player's WAIT state, turn toggles, timer clears.
  - Edge to next-turn acceptance is 3 cycles minimum.
- Out of turn: a non-turn player's edge while in WAIT_Px gives out_of_turn=1 for one cycle and no other effect.
- Simultaneous edges: the turn player is processed and out_of_turn pulses for the other player in the same cycle.
- Timeout: the timer counts every cycle in WAIT_Px.
  - At TIMEOUT_CYCLES-1, if no turn-player edge that cycle: timeout=1 next cycle, turn passes to the other player, timer clears, move_count unchanged.
  - An edge in the expiry cycle wins over the timeout.
- DONE: ignores all enables; no pulses, wr_en=0. Only reset exits.
- Reset mid-operation (including during COMMIT): wr_en is not asserted the following cycle and all state returns to reset values.
- move_count saturates at 9. wr_pos/wr_player hold their last value when wr_en=0.

Test Plan:
1. Release reset with enables low; raise P1 enable with pos=4 → wr_en=1 one cycle later with wr_pos=4, wr_player=01, move_count=1; turn=10 two cycles after the strobe.
2. On P2's turn, raise P2 enable with pos=9, then pos=4 while board_cells[9:8]=01 → two illegal_move pulses, no wr_en, turn stays 10.
3. Hold player1_enable high through reset release → no move accepted; drop it and raise it again with pos=0 → accepted.
4. Raise P1 and P2 enables in the same cycle on P1's turn → P1 move written and one out_of_turn pulse; set TIMEOUT_CYCLES=20 and leave P2 idle → timeout pulse after 20 cycles in WAIT_P2, turn=01.
5. Play P1 moves at 0, 4, 8 with valid P2 moves between, and have the board return who=01 after the P1 move at 8 → DONE, game_over=1, turn=00, move_count=5; further enables cause no wr_en and no pulses.
6. Play a nine-move sequence with who=00 throughout → game_over after the 9th strobe and move_count=9.

Source files
------------

// File: rtl/ttt_turn_arbiter.sv
// Turn arbiter for a tic-tac-toe board: edge-detects player enables, enforces
// turn order, rejects bad or occupied cells, forfeits idle turns, and issues a
// single write strobe per accepted move until the board reports a result.
module ttt_turn_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        player1_enable,
    input  logic        player2_enable,
    input  logic [3:0]  player1_position,
    input  logic [3:0]  player2_position,
    input  logic [17:0] board_cells,
    input  logic [1:0]  who,
    output logic        wr_en,
    output logic [3:0]  wr_pos,
    output logic [1:0]  wr_player,
    output logic [1:0]  turn,
    output logic        illegal_move,
    output logic        out_of_turn,
    output logic        timeout,
    output logic [3:0]  move_count,
    output logic        game_over
);

    typedef enum logic [2:0] {
        WAIT_P1,
        WAIT_P2,
        COMMIT,
        CHECK,
        DONE
    } state_t;

    // Expiry compares with >= so an illegal edge that masks the expiry cycle
    // still forfeits the turn on the following cycle.
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ?
                                            TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             state_q, state_d;
    logic               en1_q, en1_d, en2_q, en2_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               wr_en_q, wr_en_d;
    logic [3:0]         wr_pos_q, wr_pos_d;
    logic [1:0]         wr_player_q, wr_player_d;
    logic               illegal_q, illegal_d;
    logic               oot_q, oot_d;
    logic               tmo_q, tmo_d;
    logic [3:0]         count_q, count_d;

    // Indices 9..15 read as occupied so one lookup covers range and occupancy.
    logic [1:0] cells [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_cell
        if (gi < 9) begin : g_real
            assign cells[gi] = board_cells[2*gi +: 2];
        end else begin : g_pad
            assign cells[gi] = 2'b11;
        end
    end

    logic       edge1, edge2;
    logic       p1_turn;
    logic       turn_edge, other_edge;
    logic [3:0] turn_pos;

    assign edge1      = player1_enable & ~en1_q;
    assign edge2      = player2_enable & ~en2_q;
    assign p1_turn    = (state_q == WAIT_P1);
    assign turn_edge  = p1_turn ? edge1 : edge2;
    assign other_edge = p1_turn ? edge2 : edge1;
    assign turn_pos   = p1_turn ? player1_position : player2_position;

    // Next-state, move acceptance, pulse generation and turn timer.
    always_comb begin
        state_d     = state_q;
        en1_d       = player1_enable;
        en2_d       = player2_enable;
        timer_d     = timer_q;
        wr_en_d     = 1'b0;
        wr_pos_d    = wr_pos_q;
        wr_player_d = wr_player_q;
        illegal_d   = 1'b0;
        oot_d       = 1'b0;
        tmo_d       = 1'b0;
        count_d     = count_q;
        case (state_q)
            WAIT_P1, WAIT_P2: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                oot_d = other_edge;
                if (turn_edge) begin
                    if (cells[turn_pos] != 2'b00) begin
                        illegal_d = 1'b1;
                    end else begin
                        wr_en_d     = 1'b1;
                        wr_pos_d    = turn_pos;
                        wr_player_d = p1_turn ? 2'b01 : 2'b10;
                        count_d     = (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
                        timer_d     = '0;
                        state_d     = COMMIT;
                    end
                end else if (TMO_EN && (timer_q >= TMO_LAST)) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = p1_turn ? WAIT_P2 : WAIT_P1;
                end
            end
            COMMIT: begin
                state_d = CHECK;
            end
            CHECK: begin
                timer_d = '0;
                if ((who != 2'b00) || (count_q == 4'd9)) begin
                    state_d = DONE;
                end else begin
                    state_d = (wr_player_q == 2'b01) ? WAIT_P2 : WAIT_P1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_P1;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= WAIT_P1;
            en1_q       <= 1'b1;
            en2_q       <= 1'b1;
            timer_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_pos_q    <= 4'd0;
            wr_player_q <= 2'b00;
            illegal_q   <= 1'b0;
            oot_q       <= 1'b0;
            tmo_q       <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            en1_q       <= en1_d;
            en2_q       <= en2_d;
            timer_q     <= timer_d;
            wr_en_q     <= wr_en_d;
            wr_pos_q    <= wr_pos_d;
            wr_player_q <= wr_player_d;
            illegal_q   <= illegal_d;
            oot_q       <= oot_d;
            tmo_q       <= tmo_d;
            count_q     <= count_d;
        end
    end

    // While a move is in flight the mover still holds the turn.
    always_comb begin
        case (state_q)
            WAIT_P1:       turn = 2'b01;
            WAIT_P2:       turn = 2'b10;
            COMMIT, CHECK: turn = wr_player_q;
            default:       turn = 2'b00;
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_pos       = wr_pos_q;
    assign wr_player    = wr_player_q;
    assign illegal_move = illegal_q;
    assign out_of_turn  = oot_q;
    assign timeout      = tmo_q;
    assign move_count   = count_q;
    assign game_over    = (state_q == DONE);

endmodule

// File: tb/tb_ttt_turn_arbiter.sv
// Bench for ttt_turn_arbiter: a game-level model predicts every output each
// cycle; directed scenarios add literal expectations that pin the model.
module tb_ttt_turn_arbiter;

    localparam int TMO = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p1_en = 1'b0, p2_en = 1'b0;
    logic [3:0]  p1_pos = 4'd0, p2_pos = 4'd0;
    logic [17:0] board_cells;
    logic [1:0]  who_r = 2'b00;
    logic        wr_en, illegal_move, out_of_turn, timeout, game_over;
    logic [3:0]  wr_pos, move_count;
    logic [1:0]  wr_player, turn;

    logic [1:0]  bd [9];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ttt_turn_arbiter #(.TIMEOUT_CYCLES(TMO), .TMR_W(16)) dut (
        .clock(clock), .reset(reset),
        .player1_enable(p1_en), .player2_enable(p2_en),
        .player1_position(p1_pos), .player2_position(p2_pos),
        .board_cells(board_cells), .who(who_r),
        .wr_en(wr_en), .wr_pos(wr_pos), .wr_player(wr_player), .turn(turn),
        .illegal_move(illegal_move), .out_of_turn(out_of_turn),
        .timeout(timeout), .move_count(move_count), .game_over(game_over)
    );

    always_comb begin
        board_cells = '0;
        for (int i = 0; i < 9; i++) board_cells[2*i +: 2] = bd[i];
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game-level model: whose move it is, how many cycles a move stays in
    // flight, and how long the mover has idled.
    bit m_valid = 0;
    bit m_h1, m_h2, m_over, m_wr_en, m_ill, m_oot, m_tmo;
    int m_mover, m_busy, m_idle, m_moves, m_wr_pos, m_wr_pl;

    always @(posedge clock) begin
        bit e1, e2, te, oe;
        int p;
        if (!reset) begin
            m_valid = 1; m_h1 = 1; m_h2 = 1; m_over = 0;
            m_mover = 1; m_busy = 0; m_idle = 0; m_moves = 0;
            m_wr_en = 0; m_wr_pos = 0; m_wr_pl = 0;
            m_ill = 0; m_oot = 0; m_tmo = 0;
        end else if (m_valid) begin
            e1 = p1_en && !m_h1;
            e2 = p2_en && !m_h2;
            m_h1 = p1_en;
            m_h2 = p2_en;
            m_wr_en = 0; m_ill = 0; m_oot = 0; m_tmo = 0;
            if (m_over) begin
                m_busy = 0;
            end else if (m_busy == 2) begin
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_busy = 0;
                if (who_r != 2'b00 || m_moves == 9) m_over = 1;
                else begin m_mover = 3 - m_mover; m_idle = 0; end
            end else begin
                te = (m_mover == 1) ? e1 : e2;
                oe = (m_mover == 1) ? e2 : e1;
                p  = (m_mover == 1) ? int'(p1_pos) : int'(p2_pos);
                m_idle++;
                if (oe) m_oot = 1;
                if (te) begin
                    if (p > 8) m_ill = 1;
                    else if (bd[p] != 2'b00) m_ill = 1;
                    else begin
                        m_wr_en = 1; m_wr_pos = p; m_wr_pl = m_mover;
                        m_moves = (m_moves < 9) ? m_moves + 1 : 9;
                        m_busy = 2; m_idle = 0;
                    end
                end else if (m_idle >= TMO) begin
                    m_tmo = 1; m_mover = 3 - m_mover; m_idle = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model; also plays the board.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("wr_en", int'(wr_en), int'(m_wr_en));
            chk("wr_pos", int'(wr_pos), m_wr_pos);
            chk("wr_player", int'(wr_player), m_wr_pl);
            chk("turn", int'(turn), m_over ? 0 : m_mover);
            chk("illegal_move", int'(illegal_move), int'(m_ill));
            chk("out_of_turn", int'(out_of_turn), int'(m_oot));
            chk("timeout", int'(timeout), int'(m_tmo));
            chk("move_count", int'(move_count), m_moves);
            chk("game_over", int'(game_over), int'(m_over));
            if (m_wr_en && reset) bd[m_wr_pos] = 2'(m_wr_pl);
        end
        if (!reset) for (int i = 0; i < 9; i++) bd[i] = 2'b00;
    end

    int s_wr_en, s_wr_pos, s_wr_pl, s_ill, s_oot, s_mc;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        who_r = 2'b00;
        tick(2);
        reset = 1'b1;
    endtask

    // Raise the enable for one sampling edge, snapshot the cycle after.
    task automatic press(input int pl, input int pos, input bit both);
        if (pl == 1 || both) begin p1_en = 1'b1; p1_pos = 4'(pos); end
        if (pl == 2 || both) begin p2_en = 1'b1; p2_pos = 4'(pos); end
        @(negedge clock);
        s_wr_en = wr_en; s_wr_pos = wr_pos; s_wr_pl = wr_player;
        s_ill = illegal_move; s_oot = out_of_turn; s_mc = move_count;
        $display("move p%0d pos=%0d both=%0d: wr_en=%0d wr_pos=%0d ill=%0d oot=%0d count=%0d",
                 pl, pos, both, s_wr_en, s_wr_pos, s_ill, s_oot, s_mc);
        p1_en = 1'b0;
        p2_en = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        // 1: basic accepted move
        do_reset();
        chk("rst_turn", int'(turn), 1);
        chk("rst_count", int'(move_count), 0);
        tick(1);
        press(1, 4, 0);
        chk("t1_wr_en", s_wr_en, 1);
        chk("t1_wr_pos", s_wr_pos, 4);
        chk("t1_wr_pl", s_wr_pl, 1);
        chk("t1_count", s_mc, 1);
        chk("t1_turn_check", int'(turn), 1);
        tick(1);
        chk("t1_turn_p2", int'(turn), 2);

        // 2: out-of-range and occupied positions
        press(2, 9, 0);
        chk("t2_ill_range", s_ill, 1);
        chk("t2_no_wr_a", s_wr_en, 0);
        press(2, 4, 0);
        chk("t2_ill_occ", s_ill, 1);
        chk("t2_no_wr_b", s_wr_en, 0);
        chk("t2_turn", int'(turn), 2);

        // 3: enable held through reset release is not a move
        @(negedge clock);
        p1_en = 1'b1; p1_pos = 4'd3;
        do_reset();
        tick(3);
        chk("t3_held_count", int'(move_count), 0);
        chk("t3_held_wr", int'(wr_en), 0);
        p1_en = 1'b0;
        tick(1);
        press(1, 0, 0);
        chk("t3_wr_en", s_wr_en, 1);
        chk("t3_wr_pos", s_wr_pos, 0);

        // 4: simultaneous edges, then P2 idles into a timeout
        do_reset();
        tick(1);
        press(1, 2, 1);
        chk("t4_wr_en", s_wr_en, 1);
        chk("t4_wr_pos", s_wr_pos, 2);
        chk("t4_oot", s_oot, 1);
        tick(TMO);
        chk("t4_pre_tmo", int'(timeout), 0);
        chk("t4_pre_turn", int'(turn), 2);
        tick(1);
        chk("t4_tmo", int'(timeout), 1);
        chk("t4_turn", int'(turn), 1);
        chk("t4_count", int'(move_count), 1);

        // 5: P1 wins on diagonal 0-4-8
        do_reset();
        tick(1);
        press(1, 0, 0); tick(1);
        press(2, 1, 0); tick(1);
        press(1, 4, 0); tick(1);
        press(2, 2, 0); tick(1);
        press(1, 8, 0);
        who_r = 2'b01;
        tick(1);
        chk("t5_over", int'(game_over), 1);
        chk("t5_turn", int'(turn), 0);
        chk("t5_count", int'(move_count), 5);
        press(1, 3, 0);
        chk("t5_no_wr", s_wr_en, 0);
        press(2, 5, 0);
        chk("t5_no_oot", s_oot, 0);
        chk("t5_no_ill", s_ill, 0);

        // 6: full board, no winner reported
        do_reset();
        tick(1);
        for (int i = 0; i < 9; i++) begin
            press((i % 2) + 1, i, 0);
            if (i == 7) chk("t6_not_over", int'(game_over), 0);
            tick(1);
        end
        chk("t6_count", int'(move_count), 9);
        chk("t6_over", int'(game_over), 1);
        chk("t6_turn", int'(turn), 0);

        // 7: reset during the write strobe
        do_reset();
        tick(1);
        p1_en = 1'b1; p1_pos = 4'd5;
        @(negedge clock);
        chk("t7_wr_en", int'(wr_en), 1);
        reset = 1'b0;
        p1_en = 1'b0;
        @(negedge clock);
        chk("t7_wr_cut", int'(wr_en), 0);
        chk("t7_count", int'(move_count), 0);
        reset = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
